tlb_param: RTL and testbench

//  Parametrised fully-associative MIPS-style joint TLB: LPORTS independent lookup ports (IF/MEM/...),

---
 rtl/tlb_param.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_tlb_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_param.sv
// Fully-associative MIPS-style joint TLB with LPORTS registered lookup ports,
// variable page size, TLBWI/TLBWR/TLBR access, a Random register and a
// sequential invalidate walk (all entries or one non-global ASID).
module tlb_param #(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned LPORTS  = 2,
    parameter int unsigned VPN2_W  = 19,
    parameter int unsigned ASID_W  = 8,
    parameter int unsigned MASK_W  = 12,
    parameter int unsigned PFN_W   = 20,
    localparam int unsigned IDX_W  = $clog2(ENTRIES),
    localparam int unsigned VPN_W  = VPN2_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    // lookup ports
    input  logic [LPORTS-1:0]          lk_req_i,
    input  logic [LPORTS*VPN_W-1:0]    lk_vpn_i,
    input  logic [LPORTS*ASID_W-1:0]   lk_asid_i,
    output logic [LPORTS-1:0]          lk_hit_o,
    output logic [LPORTS*IDX_W-1:0]    lk_index_o,
    output logic [LPORTS*PFN_W-1:0]    lk_pfn_o,
    output logic [LPORTS*3-1:0]        lk_c_o,
    output logic [LPORTS-1:0]          lk_d_o,
    output logic [LPORTS-1:0]          lk_v_o,
    // TLBWI / TLBWR
    input  logic                       w_en_i,
    input  logic                       w_random_i,
    input  logic [IDX_W-1:0]           w_index_i,
    input  logic [VPN2_W-1:0]          w_vpn2_i,
    input  logic [ASID_W-1:0]          w_asid_i,
    input  logic [MASK_W-1:0]          w_mask_i,
    input  logic                       w_g_i,
    input  logic [PFN_W-1:0]           w_pfn0_i,
    input  logic [4:0]                 w_flags0_i,
    input  logic [PFN_W-1:0]           w_pfn1_i,
    input  logic [4:0]                 w_flags1_i,
    // TLBR
    input  logic                       r_en_i,
    input  logic [IDX_W-1:0]           r_index_i,
    output logic [VPN2_W-1:0]          r_vpn2_o,
    output logic [ASID_W-1:0]          r_asid_o,
    output logic [MASK_W-1:0]          r_mask_o,
    output logic                       r_g_o,
    output logic [PFN_W-1:0]           r_pfn0_o,
    output logic [4:0]                 r_flags0_o,
    output logic [PFN_W-1:0]           r_pfn1_o,
    output logic [4:0]                 r_flags1_o,
    // Random / Wired
    input  logic [IDX_W-1:0]           wired_i,
    output logic [IDX_W-1:0]           rand_index_o,
    // invalidate walk
    input  logic                       flush_i,
    input  logic                       flush_asid_en_i,
    input  logic [ASID_W-1:0]          flush_asid_i,
    output logic                       busy_o
);

    localparam int unsigned KW = $clog2(MASK_W + 1);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ENTRIES - 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StWalk = 1'b1;

    // Number of set mask bits; only contiguous-from-LSB masks are meaningful.
    function automatic logic [KW-1:0] popcnt(input logic [MASK_W-1:0] m);
        logic [KW-1:0] cnt;
        cnt = '0;
        for (int b = 0; b < MASK_W; b++) begin
            cnt = cnt + KW'(m[b]);
        end
        return cnt;
    endfunction

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] ev_q, ev_d;
    logic [ENTRIES-1:0] e_g_q;
    logic [VPN2_W-1:0]  e_vpn2_q   [ENTRIES];
    logic [ASID_W-1:0]  e_asid_q   [ENTRIES];
    logic [MASK_W-1:0]  e_mask_q   [ENTRIES];
    logic [PFN_W-1:0]   e_pfn0_q   [ENTRIES];
    logic [4:0]         e_flags0_q [ENTRIES];
    logic [PFN_W-1:0]   e_pfn1_q   [ENTRIES];
    logic [4:0]         e_flags1_q [ENTRIES];

    // Per-entry page-size decode shared by all ports
    logic [KW-1:0]      ent_k [ENTRIES];
    logic [VPN2_W-1:0]  ent_m [ENTRIES];
    logic [PFN_W-1:0]   ent_l [ENTRIES];

    // Control state
    logic [0:0]         state_q, state_d;
    logic [IDX_W-1:0]   walk_idx_q, walk_idx_d;
    logic               fl_asid_en_q, fl_asid_en_d;
    logic [ASID_W-1:0]  fl_asid_q, fl_asid_d;
    logic [IDX_W-1:0]   rand_q, rand_d;
    logic [IDX_W-1:0]   wired_q;

    logic               busy;
    logic               wr_go;
    logic               rd_go;
    logic [IDX_W-1:0]   w_idx;

    // Lookup next-state and registered results
    logic [LPORTS-1:0]             lk_hit_d, lk_hit_q;
    logic [LPORTS-1:0][IDX_W-1:0]  lk_idx_d, lk_idx_q;
    logic [LPORTS-1:0][PFN_W-1:0]  lk_pfn_d, lk_pfn_q;
    logic [LPORTS-1:0][4:0]        lk_flags_d, lk_flags_q;

    // CP0 stalls on busy_o, so all CP0-side requests are dropped during the walk.
    assign busy  = (state_q == StWalk);
    assign wr_go = w_en_i & ~busy;
    assign rd_go = r_en_i & ~busy;
    assign w_idx = w_random_i ? rand_q : w_index_i;

    // Decode each entry's mask into match mask, odd-select bit position and PFN merge mask
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ent_k[i] = popcnt(e_mask_q[i]);
            ent_m[i] = VPN2_W'(e_mask_q[i]);
            ent_l[i] = (PFN_W'(1) << ent_k[i]) - PFN_W'(1);
        end
    end

    // Associative match per port; scanning downwards lets the lowest index win
    always_comb begin : lookup_comb
        logic [VPN_W-1:0]  vpn;
        logic [ASID_W-1:0] asid;
        logic [VPN_W-1:0]  shifted;
        logic [PFN_W-1:0]  pfn_sel;
        logic [4:0]        flags_sel;
        vpn       = '0;
        asid      = '0;
        shifted   = '0;
        pfn_sel   = '0;
        flags_sel = '0;
        lk_hit_d   = '0;
        lk_idx_d   = '0;
        lk_pfn_d   = '0;
        lk_flags_d = '0;
        for (int p = 0; p < LPORTS; p++) begin
            vpn  = lk_vpn_i[p*VPN_W +: VPN_W];
            asid = lk_asid_i[p*ASID_W +: ASID_W];
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (ev_q[i] &&
                    ((e_vpn2_q[i] & ~ent_m[i]) == (vpn[VPN_W-1:1] & ~ent_m[i])) &&
                    (e_g_q[i] || (e_asid_q[i] == asid))) begin
                    shifted   = vpn >> ent_k[i];
                    pfn_sel   = shifted[0] ? e_pfn1_q[i] : e_pfn0_q[i];
                    flags_sel = shifted[0] ? e_flags1_q[i] : e_flags0_q[i];
                    lk_hit_d[p]   = 1'b1;
                    lk_idx_d[p]   = IDX_W'(i);
                    // Large pages pass the low VPN bits straight through to the PFN
                    lk_pfn_d[p]   = (pfn_sel & ~ent_l[i]) | (PFN_W'(vpn) & ent_l[i]);
                    lk_flags_d[p] = flags_sel;
                end
            end
            if (busy) begin
                lk_hit_d[p]   = 1'b0;
                lk_idx_d[p]   = '0;
                lk_pfn_d[p]   = '0;
                lk_flags_d[p] = '0;
            end
        end
    end

    // Lookup result registers, loaded only on request and held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_hit_q   <= '0;
            lk_idx_q   <= '0;
            lk_pfn_q   <= '0;
            lk_flags_q <= '0;
        end else begin
            for (int p = 0; p < LPORTS; p++) begin
                if (lk_req_i[p]) begin
                    lk_hit_q[p]   <= lk_hit_d[p];
                    lk_idx_q[p]   <= lk_idx_d[p];
                    lk_pfn_q[p]   <= lk_pfn_d[p];
                    lk_flags_q[p] <= lk_flags_d[p];
                end
            end
        end
    end

    assign lk_hit_o   = lk_hit_q;
    assign lk_index_o = lk_idx_q;
    assign lk_pfn_o   = lk_pfn_q;

    for (genvar p = 0; p < LPORTS; p++) begin : g_lk_out
        assign lk_c_o[p*3 +: 3] = lk_flags_q[p][4:2];
        assign lk_d_o[p]        = lk_flags_q[p][1];
        assign lk_v_o[p]        = lk_flags_q[p][0];
    end

    // Entry-valid next state: writes set, the walk clears selected entries
    always_comb begin
        ev_d = ev_q;
        if (wr_go) begin
            ev_d[w_idx] = 1'b1;
        end
        if (busy && (!fl_asid_en_q ||
                     (!e_g_q[walk_idx_q] && (e_asid_q[walk_idx_q] == fl_asid_q)))) begin
            ev_d[walk_idx_q] = 1'b0;
        end
    end

    // Entry-valid bits are the only entry state that needs reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q <= '0;
        end else begin
            ev_q <= ev_d;
        end
    end

    // Entry tag/data storage; contents are qualified by ev_q so no reset needed
    always_ff @(posedge clk) begin
        if (wr_go) begin
            e_vpn2_q[w_idx]   <= w_vpn2_i;
            e_asid_q[w_idx]   <= w_asid_i;
            e_mask_q[w_idx]   <= w_mask_i;
            e_g_q[w_idx]      <= w_g_i;
            e_pfn0_q[w_idx]   <= w_pfn0_i;
            e_flags0_q[w_idx] <= w_flags0_i;
            e_pfn1_q[w_idx]   <= w_pfn1_i;
            e_flags1_q[w_idx] <= w_flags1_i;
        end
    end

    // TLBR read registers; a same-cycle write is not bypassed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpn2_o   <= '0;
            r_asid_o   <= '0;
            r_mask_o   <= '0;
            r_g_o      <= 1'b0;
            r_pfn0_o   <= '0;
            r_flags0_o <= '0;
            r_pfn1_o   <= '0;
            r_flags1_o <= '0;
        end else if (rd_go) begin
            r_vpn2_o   <= e_vpn2_q[r_index_i];
            r_asid_o   <= e_asid_q[r_index_i];
            r_mask_o   <= e_mask_q[r_index_i];
            r_g_o      <= e_g_q[r_index_i];
            r_pfn0_o   <= e_pfn0_q[r_index_i];
            r_flags0_o <= e_flags0_q[r_index_i];
            r_pfn1_o   <= e_pfn1_q[r_index_i];
            r_flags1_o <= e_flags1_q[r_index_i];
        end
    end

    // Random decrements towards Wired and wraps to the top; Wired writes restart it
    always_comb begin
        if ((wired_i != wired_q) || (rand_q <= wired_i)) begin
            rand_d = LastIdx;
        end else begin
            rand_d = rand_q - IDX_W'(1);
        end
    end

    // Random and the Wired shadow used for change detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rand_q  <= LastIdx;
            wired_q <= '0;
        end else begin
            rand_q  <= rand_d;
            wired_q <= wired_i;
        end
    end

    assign rand_index_o = rand_q;

    // Invalidate-walk FSM next state: one entry per cycle, 0 up to ENTRIES-1
    always_comb begin
        state_d      = state_q;
        walk_idx_d   = walk_idx_q;
        fl_asid_en_d = fl_asid_en_q;
        fl_asid_d    = fl_asid_q;
        case (state_q)
            StIdle: begin
                if (flush_i) begin
                    state_d      = StWalk;
                    walk_idx_d   = '0;
                    fl_asid_en_d = flush_asid_en_i;
                    fl_asid_d    = flush_asid_i;
                end
            end
            StWalk: begin
                walk_idx_d = walk_idx_q + IDX_W'(1);
                if (walk_idx_q == LastIdx) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Invalidate-walk FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            walk_idx_q   <= '0;
            fl_asid_en_q <= 1'b0;
            fl_asid_q    <= '0;
        end else begin
            state_q      <= state_d;
            walk_idx_q   <= walk_idx_d;
            fl_asid_en_q <= fl_asid_en_d;
            fl_asid_q    <= fl_asid_d;
        end
    end

    assign busy_o = busy;

endmodule

// File: tb/tb_tlb_param.sv
// Scoreboard bench for tlb_param: lookups push expected results, which are
// popped and compared once the registered outputs have loaded.
module tb_tlb_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  lk_req_i;
    logic [39:0] lk_vpn_i;
    logic [15:0] lk_asid_i;
    logic [1:0]  lk_hit_o;
    logic [9:0]  lk_index_o;
    logic [39:0] lk_pfn_o;
    logic [5:0]  lk_c_o;
    logic [1:0]  lk_d_o;
    logic [1:0]  lk_v_o;
    logic        w_en_i, w_random_i, w_g_i;
    logic [4:0]  w_index_i;
    logic [18:0] w_vpn2_i;
    logic [7:0]  w_asid_i;
    logic [11:0] w_mask_i;
    logic [19:0] w_pfn0_i, w_pfn1_i;
    logic [4:0]  w_flags0_i, w_flags1_i;
    logic        r_en_i;
    logic [4:0]  r_index_i;
    logic [18:0] r_vpn2_o;
    logic [7:0]  r_asid_o;
    logic [11:0] r_mask_o;
    logic        r_g_o;
    logic [19:0] r_pfn0_o, r_pfn1_o;
    logic [4:0]  r_flags0_o, r_flags1_o;
    logic [4:0]  wired_i;
    logic [4:0]  rand_index_o;
    logic        flush_i, flush_asid_en_i;
    logic [7:0]  flush_asid_i;
    logic        busy_o;

    tlb_param dut (
        .clk(clk), .rst(rst),
        .lk_req_i(lk_req_i), .lk_vpn_i(lk_vpn_i), .lk_asid_i(lk_asid_i),
        .lk_hit_o(lk_hit_o), .lk_index_o(lk_index_o), .lk_pfn_o(lk_pfn_o),
        .lk_c_o(lk_c_o), .lk_d_o(lk_d_o), .lk_v_o(lk_v_o),
        .w_en_i(w_en_i), .w_random_i(w_random_i), .w_index_i(w_index_i),
        .w_vpn2_i(w_vpn2_i), .w_asid_i(w_asid_i), .w_mask_i(w_mask_i), .w_g_i(w_g_i),
        .w_pfn0_i(w_pfn0_i), .w_flags0_i(w_flags0_i), .w_pfn1_i(w_pfn1_i),
        .w_flags1_i(w_flags1_i),
        .r_en_i(r_en_i), .r_index_i(r_index_i),
        .r_vpn2_o(r_vpn2_o), .r_asid_o(r_asid_o), .r_mask_o(r_mask_o), .r_g_o(r_g_o),
        .r_pfn0_o(r_pfn0_o), .r_flags0_o(r_flags0_o), .r_pfn1_o(r_pfn1_o),
        .r_flags1_o(r_flags1_o),
        .wired_i(wired_i), .rand_index_o(rand_index_o),
        .flush_i(flush_i), .flush_asid_en_i(flush_asid_en_i), .flush_asid_i(flush_asid_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic       hit;
        int         idx;
        logic [19:0] pfn;
        logic [4:0] flags;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue a lookup on one port with its expected registered result
    task automatic lookup(input int port, input logic [19:0] vpn, input logic [7:0] asid,
                          input logic hit, input int idx, input logic [19:0] pfn,
                          input logic [4:0] flags, input string tag);
        exp_t e;
        lk_req_i[port]           = 1'b1;
        lk_vpn_i[port*20 +: 20]  = vpn;
        lk_asid_i[port*8 +: 8]   = asid;
        e.port = port; e.hit = hit; e.idx = idx; e.pfn = pfn; e.flags = flags;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic wr(input logic random, input logic [4:0] idx, input logic [18:0] vpn2,
                      input logic [7:0] asid, input logic [11:0] mask, input logic g,
                      input logic [19:0] pfn0, input logic [4:0] f0,
                      input logic [19:0] pfn1, input logic [4:0] f1);
        w_en_i = 1'b1; w_random_i = random; w_index_i = idx; w_vpn2_i = vpn2;
        w_asid_i = asid; w_mask_i = mask; w_g_i = g; w_pfn0_i = pfn0; w_flags0_i = f0;
        w_pfn1_i = pfn1; w_flags1_i = f1;
    endtask

    // Advance one clock, drop pulses, then drain the scoreboard
    task automatic step();
        tick();
        lk_req_i = '0; w_en_i = 1'b0; w_random_i = 1'b0; r_en_i = 1'b0; flush_i = 1'b0;
        while (sb.size() > 0) begin
            exp_t  e;
            string t;
            e = sb.pop_front();
            t = sb_tag.pop_front();
            check({t, "_hit"}, 64'(lk_hit_o[e.port]), 64'(e.hit));
            check({t, "_idx"}, 64'(lk_index_o[e.port*5 +: 5]), 64'(e.idx));
            check({t, "_pfn"}, 64'(lk_pfn_o[e.port*20 +: 20]), 64'(e.pfn));
            check({t, "_flags"},
                  64'({lk_c_o[e.port*3 +: 3], lk_d_o[e.port], lk_v_o[e.port]}),
                  64'(e.flags));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int guard;
        rst = 1'b1;
        lk_req_i = '0; lk_vpn_i = '0; lk_asid_i = '0;
        w_en_i = 0; w_random_i = 0; w_index_i = '0; w_vpn2_i = '0; w_asid_i = '0;
        w_mask_i = '0; w_g_i = 0; w_pfn0_i = '0; w_pfn1_i = '0; w_flags0_i = '0;
        w_flags1_i = '0; r_en_i = 0; r_index_i = '0; wired_i = '0;
        flush_i = 0; flush_asid_en_i = 0; flush_asid_i = '0;

        // Reset state
        tick(); tick();
        check("rst_rand", 64'(rand_index_o), 64'(31));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_hit", 64'(lk_hit_o), 64'(0));
        check("rst_rpfn", 64'(r_pfn0_o), 64'(0));
        rst = 1'b0;
        lookup(0, 20'h00021, 8'd3, 1'b0, 0, 20'h0, 5'h0, "rst_lk0");
        lookup(1, 20'h12345, 8'd0, 1'b0, 0, 20'h0, 5'h0, "rst_lk1");
        step();

        // TLBWI idx5; a same-cycle lookup still sees the old (invalid) entry
        wr(1'b0, 5'd5, 19'h00010, 8'd3, 12'h000, 1'b0, 20'h100, 5'h0F, 20'h200, 5'h0F);
        lookup(0, 20'h00021, 8'd3, 1'b0, 0, 20'h0, 5'h0, "wr_same_cycle");
        step();
        lookup(0, 20'h00021, 8'd3, 1'b1, 5, 20'h200, 5'h0F, "idx5_odd");
        lookup(1, 20'h00020, 8'd3, 1'b1, 5, 20'h100, 5'h0F, "idx5_even");
        step();
        lookup(0, 20'h00021, 8'd4, 1'b0, 0, 20'h0, 5'h0, "idx5_asid_miss");
        step();

        // Global 16KB-page entry at idx6 overlapping idx5
        wr(1'b0, 5'd6, 19'h00010, 8'd9, 12'h003, 1'b1, 20'h400, 5'h01, 20'h600, 5'h03);
        step();
        lookup(0, 20'h00021, 8'd4, 1'b1, 6, 20'h401, 5'h01, "mask_even");
        lookup(1, 20'h00025, 8'd3, 1'b1, 6, 20'h601, 5'h03, "mask_odd");
        step();
        lookup(1, 20'h00021, 8'd3, 1'b1, 5, 20'h200, 5'h0F, "prio_lowest");
        step();

        // TLBR with a same-cycle write to the same index returns old data
        wr(1'b0, 5'd6, 19'h00010, 8'd9, 12'h003, 1'b1, 20'h444, 5'h01, 20'h600, 5'h03);
        r_en_i = 1'b1; r_index_i = 5'd6;
        step();
        check("tlbr_old_pfn0", 64'(r_pfn0_o), 64'(20'h400));
        check("tlbr_mask", 64'(r_mask_o), 64'(12'h003));
        check("tlbr_g6", 64'(r_g_o), 64'(1));
        r_en_i = 1'b1; r_index_i = 5'd5;
        step();
        check("tlbr_vpn2", 64'(r_vpn2_o), 64'(19'h00010));
        check("tlbr_asid", 64'(r_asid_o), 64'(3));
        check("tlbr_g5", 64'(r_g_o), 64'(0));
        check("tlbr_pfn1", 64'(r_pfn1_o), 64'(20'h200));
        check("tlbr_flags0", 64'(r_flags0_o), 64'(5'h0F));
        r_en_i = 1'b1; r_index_i = 5'd6;
        step();
        check("tlbr_new_pfn0", 64'(r_pfn0_o), 64'(20'h444));
        check("tlbr_flags1", 64'(r_flags1_o), 64'(5'h03));

        // Random with Wired=8: 31 down to 8, then wrap
        wired_i = 5'd8;
        for (int e = 31; e >= 8; e--) begin
            tick();
            check("rand_seq", 64'(rand_index_o), 64'(e));
        end
        tick();
        check("rand_wrap", 64'(rand_index_o), 64'(31));

        // 25 back-to-back TLBWRs starting at Random=31; expected slot 31-(n mod 24)
        for (int n = 0; n < 25; n++) begin
            wr(1'b1, 5'd0, 19'(32'h100 + n), 8'd0, 12'h000, 1'b1,
               20'(n), 5'h01, 20'(32'h800 + n), 5'h01);
            step();
        end
        lookup(0, 20'h00203, 8'd0, 1'b1, 30, 20'h801, 5'h01, "tlbwr_n1");
        lookup(1, 20'h0022F, 8'd0, 1'b1, 8, 20'h817, 5'h01, "tlbwr_n23");
        step();
        lookup(0, 20'h00231, 8'd0, 1'b1, 31, 20'h818, 5'h01, "tlbwr_wrap");
        lookup(1, 20'h00201, 8'd0, 1'b0, 0, 20'h0, 5'h0, "tlbwr_overwritten");
        step();
        lookup(0, 20'h00021, 8'd3, 1'b1, 5, 20'h200, 5'h0F, "wired_kept");
        step();

        // ASID flush setup
        wr(1'b0, 5'd1, 19'h00050, 8'd3, 12'h000, 1'b0, 20'h155, 5'h01, 20'h156, 5'h01);
        step();
        wr(1'b0, 5'd2, 19'h00030, 8'd3, 12'h000, 1'b1, 20'h111, 5'h01, 20'h222, 5'h01);
        step();
        wr(1'b0, 5'd3, 19'h00040, 8'd4, 12'h000, 1'b0, 20'h333, 5'h01, 20'h334, 5'h01);
        step();
        flush_i = 1'b1; flush_asid_en_i = 1'b1; flush_asid_i = 8'd3;
        step();
        cnt = busy_o ? 1 : 0;
        // During the walk: lookup misses, write and a second flush are ignored
        lookup(0, 20'h00060, 8'd3, 1'b0, 0, 20'h0, 5'h0, "walk_lk_miss");
        wr(1'b0, 5'd7, 19'h00070, 8'd0, 12'h000, 1'b1, 20'h777, 5'h01, 20'h778, 5'h01);
        flush_i = 1'b1; flush_asid_en_i = 1'b0;
        step();
        if (busy_o) cnt++;
        guard = 0;
        while (busy_o && guard < 100) begin
            tick();
            guard++;
            if (busy_o) cnt++;
        end
        check("busy_cycles", 64'(cnt), 64'(32));
        lookup(0, 20'h000A0, 8'd3, 1'b0, 0, 20'h0, 5'h0, "flush_nong_miss");
        lookup(1, 20'h00061, 8'd3, 1'b1, 2, 20'h222, 5'h01, "flush_g_hit");
        step();
        lookup(0, 20'h00080, 8'd4, 1'b1, 3, 20'h333, 5'h01, "flush_other_asid");
        lookup(1, 20'h000E0, 8'd0, 1'b0, 0, 20'h0, 5'h0, "walk_write_ignored");
        step();
        lookup(0, 20'h00021, 8'd3, 1'b1, 6, 20'h445, 5'h01, "flush_idx5_gone");
        lookup(1, 20'h00203, 8'd0, 1'b1, 30, 20'h801, 5'h01, "flush_g_kept");
        step();

        // Full flush interrupted by reset at walk cycle 10
        flush_i = 1'b1; flush_asid_en_i = 1'b0;
        step();
        check("full_busy", 64'(busy_o), 64'(1));
        repeat (9) tick();
        rst = 1'b1;
        #1;
        check("midwalk_busy", 64'(busy_o), 64'(0));
        check("midwalk_rand", 64'(rand_index_o), 64'(31));
        check("midwalk_hit", 64'(lk_hit_o), 64'(0));
        tick();
        rst = 1'b0;
        lookup(0, 20'h00021, 8'd3, 1'b0, 0, 20'h0, 5'h0, "post_rst_idx6");
        lookup(1, 20'h00203, 8'd0, 1'b0, 0, 20'h0, 5'h0, "post_rst_idx30");
        step();
        check("post_rst_busy", 64'(busy_o), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
